// File: rtl/tile_hit_detector_pkg.sv
// Shared game definitions for the tile hit detector: lane count, field widths,
// hit-FSM state encoding and a saturating counter helper.
package tile_hit_detector_pkg;

    localparam int NUM_TILES  = 4;
    localparam int TILE_IDX_W = 2;
    localparam int RGB_W      = 8;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_LATCHED  = 2'd1,
        ST_COOLDOWN = 2'd2
    } hit_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/tile_priority_enc.sv
// Lowest-index-first priority encoder over the four tile drawing requests.
module tile_priority_enc
    import tile_hit_detector_pkg::*;
(
    input  logic [3:0]            i_vec,
    output logic [TILE_IDX_W-1:0] o_index,
    output logic                  o_valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_index = '0;
        o_valid = 1'b0;
        if (i_vec[0]) begin
            o_index = 2'd0;
            o_valid = 1'b1;
        end else if (i_vec[1]) begin
            o_index = 2'd1;
            o_valid = 1'b1;
        end else if (i_vec[2]) begin
            o_index = 2'd2;
            o_valid = 1'b1;
        end else if (i_vec[3]) begin
            o_index = 2'd3;
            o_valid = 1'b1;
        end
    end

endmodule

// File: rtl/tile_hit_detector.sv
// Merges tile lanes into one registered pixel stream and reports at most one
// player/tile collision per frame, followed by a frame-counted cooldown.
module tile_hit_detector #(
    parameter int COOLDOWN_FRAMES = 15,
    parameter int NUM_TILES       = tile_hit_detector_pkg::NUM_TILES
) (
    input  logic                                       clk,
    input  logic                                       resetN,
    input  logic                                       startOfFrame,
    input  logic                                       startOfLevel,
    input  logic                                       playerDR,
    input  logic [NUM_TILES-1:0]                       tileDRVector,
    input  logic [NUM_TILES-1:0][tile_hit_detector_pkg::RGB_W-1:0] tileRGBVector,
    output logic                                       tilesDR,
    output logic [tile_hit_detector_pkg::RGB_W-1:0]    tilesRGB,
    output logic                                       tileHitPulse,
    output logic [tile_hit_detector_pkg::TILE_IDX_W-1:0] hitTileIndex,
    output logic [7:0]                                 hitCount
);

    import tile_hit_detector_pkg::*;

    localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);

    logic [TILE_IDX_W-1:0] w_first_idx;
    logic                  w_first_valid;
    logic                  w_collision;

    hit_state_t            r_state;
    logic [TILE_IDX_W-1:0] r_latched_idx;
    logic [7:0]            r_frame_cnt;
    logic                  r_tiles_dr;
    logic [RGB_W-1:0]      r_tiles_rgb;
    logic                  r_hit_pulse;
    logic [TILE_IDX_W-1:0] r_hit_idx;
    logic [7:0]            r_hit_count;

    // One encoder feeds both the RGB mux and the index captured on a collision.
    tile_priority_enc u_prio (
        .i_vec   (tileDRVector),
        .o_index (w_first_idx),
        .o_valid (w_first_valid)
    );

    assign w_collision = playerDR && w_first_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_tiles_dr  <= 1'b0;
            r_tiles_rgb <= '0;
        end else begin
            r_tiles_dr  <= w_first_valid;
            r_tiles_rgb <= w_first_valid ? tileRGBVector[w_first_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_ARMED;
            r_latched_idx <= '0;
            r_frame_cnt   <= '0;
            r_hit_pulse   <= 1'b0;
            r_hit_idx     <= '0;
            r_hit_count   <= '0;
        end else if (startOfLevel) begin
            // Level start dominates a coincident frame start and drops any pending report.
            r_state     <= ST_ARMED;
            r_frame_cnt <= '0;
            r_hit_pulse <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_hit_pulse <= 1'b0;
            unique case (r_state)
                ST_ARMED: begin
                    if (w_collision) begin
                        r_latched_idx <= w_first_idx;
                        r_state       <= ST_LATCHED;
                    end
                end
                ST_LATCHED: begin
                    if (startOfFrame) begin
                        r_hit_pulse <= 1'b1;
                        r_hit_idx   <= r_latched_idx;
                        r_hit_count <= sat_inc8(r_hit_count);
                        r_frame_cnt <= COOLDOWN_LOAD;
                        r_state     <= (COOLDOWN_LOAD == 8'd0) ? ST_ARMED : ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    // Treating 0 like 1 keeps the counter from ever wrapping.
                    if (startOfFrame) begin
                        if (r_frame_cnt <= 8'd1) begin
                            r_frame_cnt <= '0;
                            r_state     <= ST_ARMED;
                        end else begin
                            r_frame_cnt <= r_frame_cnt - 8'd1;
                        end
                    end
                end
                default: r_state <= ST_ARMED;
            endcase
        end
    end

    assign tilesDR      = r_tiles_dr;
    assign tilesRGB     = r_tiles_rgb;
    assign tileHitPulse = r_hit_pulse;
    assign hitTileIndex = r_hit_idx;
    assign hitCount     = r_hit_count;

endmodule

// File: tb/tb_tile_hit_detector.sv
// Directed bench for tile_hit_detector: two instances share stimulus, one with
// a 2-frame cooldown and one with no cooldown.
module tb_tile_hit_detector;

    logic            clk = 1'b0;
    logic            resetN;
    logic            startOfFrame;
    logic            startOfLevel;
    logic            playerDR;
    logic [3:0]      tileDRVector;
    logic [3:0][7:0] tileRGBVector;

    logic       dr2, dr0;
    logic [7:0] rgb2, rgb0;
    logic       pulse2, pulse0;
    logic [1:0] idx2, idx0;
    logic [7:0] cnt2, cnt0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tile_hit_detector #(.COOLDOWN_FRAMES(2), .NUM_TILES(4)) dut2 (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .startOfLevel  (startOfLevel),
        .playerDR      (playerDR),
        .tileDRVector  (tileDRVector),
        .tileRGBVector (tileRGBVector),
        .tilesDR       (dr2),
        .tilesRGB      (rgb2),
        .tileHitPulse  (pulse2),
        .hitTileIndex  (idx2),
        .hitCount      (cnt2)
    );

    tile_hit_detector #(.COOLDOWN_FRAMES(0), .NUM_TILES(4)) dut0 (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .startOfLevel  (startOfLevel),
        .playerDR      (playerDR),
        .tileDRVector  (tileDRVector),
        .tileRGBVector (tileRGBVector),
        .tilesDR       (dr0),
        .tilesRGB      (rgb0),
        .tileHitPulse  (pulse0),
        .hitTileIndex  (idx0),
        .hitCount      (cnt0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic level_clear();
        startOfLevel = 1'b1;
        tick();
        startOfLevel = 1'b0;
        playerDR     = 1'b0;
        tileDRVector = 4'b0000;
        tick();
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (dr2 !== 1'b0)    begin n_errors++; $display("FAIL reset_dr2 got=%0b exp=0", dr2); end
        n_checks++; if (rgb2 !== 8'h00)  begin n_errors++; $display("FAIL reset_rgb2 got=%02h exp=00", rgb2); end
        n_checks++; if (pulse2 !== 1'b0) begin n_errors++; $display("FAIL reset_pulse2 got=%0b exp=0", pulse2); end
        n_checks++; if (idx2 !== 2'd0)   begin n_errors++; $display("FAIL reset_idx2 got=%0d exp=0", idx2); end
        n_checks++; if (cnt2 !== 8'd0)   begin n_errors++; $display("FAIL reset_cnt2 got=%0d exp=0", cnt2); end
        n_checks++; if (cnt0 !== 8'd0)   begin n_errors++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
        @(posedge clk);
        #1 resetN = 1'b1;
        tick();
    endtask

    task automatic test_merge();
        tileRGBVector = {8'h77, 8'hE0, 8'h1C, 8'h55};
        playerDR      = 1'b0;
        tileDRVector  = 4'b0110;
        tick();
        n_checks++; if (dr2 !== 1'b1)   begin n_errors++; $display("FAIL merge_0110_dr got=%0b exp=1", dr2); end
        n_checks++; if (rgb2 !== 8'h1C) begin n_errors++; $display("FAIL merge_0110_rgb got=%02h exp=1C", rgb2); end
        tileDRVector = 4'b1001;
        tick();
        n_checks++; if (rgb0 !== 8'h55) begin n_errors++; $display("FAIL merge_1001_rgb got=%02h exp=55", rgb0); end
        tileDRVector = 4'b1000;
        tick();
        n_checks++; if (rgb2 !== 8'h77) begin n_errors++; $display("FAIL merge_1000_rgb got=%02h exp=77", rgb2); end
        tileDRVector = 4'b0000;
        tick();
        n_checks++; if (dr2 !== 1'b0)   begin n_errors++; $display("FAIL merge_none_dr got=%0b exp=0", dr2); end
        n_checks++; if (rgb2 !== 8'h00) begin n_errors++; $display("FAIL merge_none_rgb got=%02h exp=00", rgb2); end
    endtask

    task automatic test_basic_hit();
        level_clear();
        tick();
        playerDR     = 1'b1;
        tileDRVector = 4'b1000;
        tick();
        playerDR     = 1'b0;
        tileDRVector = 4'b0000;
        tick();
        tick();
        n_checks++; if (pulse2 !== 1'b0) begin n_errors++; $display("FAIL basic_early_pulse got=%0b exp=0", pulse2); end
        sof_tick();
        n_checks++; if (pulse2 !== 1'b1) begin n_errors++; $display("FAIL basic_pulse got=%0b exp=1", pulse2); end
        n_checks++; if (idx2 !== 2'd3)   begin n_errors++; $display("FAIL basic_idx got=%0d exp=3", idx2); end
        n_checks++; if (cnt2 !== 8'd1)   begin n_errors++; $display("FAIL basic_cnt got=%0d exp=1", cnt2); end
        tick();
        n_checks++; if (pulse2 !== 1'b0) begin n_errors++; $display("FAIL basic_pulse_width got=%0b exp=0", pulse2); end
        n_checks++; if (idx2 !== 2'd3)   begin n_errors++; $display("FAIL basic_idx_held got=%0d exp=3", idx2); end
    endtask

    task automatic test_sof_coincident();
        level_clear();
        playerDR     = 1'b1;
        tileDRVector = 4'b0100;
        sof_tick();
        playerDR     = 1'b0;
        tileDRVector = 4'b0000;
        n_checks++; if (pulse0 !== 1'b0) begin n_errors++; $display("FAIL coincide_same_frame got=%0b exp=0", pulse0); end
        for (int i = 0; i < 6; i++) tick();
        sof_tick();
        n_checks++; if (pulse0 !== 1'b1) begin n_errors++; $display("FAIL coincide_next_frame got=%0b exp=1", pulse0); end
        n_checks++; if (idx0 !== 2'd2)   begin n_errors++; $display("FAIL coincide_idx got=%0d exp=2", idx0); end
    endtask

    task automatic test_cooldown();
        int extra2;
        int extra0;
        logic exp2;
        logic exp0;
        level_clear();
        playerDR     = 1'b1;
        tileDRVector = 4'b0010;
        for (int f = 0; f < 10; f++) begin
            exp2 = (f % 3 == 1);
            exp0 = (f >= 1);
            sof_tick();
            n_checks++; if (pulse2 !== exp2) begin n_errors++; $display("FAIL cooldown2_frame%0d got=%0b exp=%0b", f, pulse2, exp2); end
            n_checks++; if (pulse0 !== exp0) begin n_errors++; $display("FAIL cooldown0_frame%0d got=%0b exp=%0b", f, pulse0, exp0); end
            if (exp2) begin
                n_checks++; if (idx2 !== 2'd1) begin n_errors++; $display("FAIL cooldown2_idx got=%0d exp=1", idx2); end
            end
            extra2 = 0;
            extra0 = 0;
            for (int c = 0; c < 7; c++) begin
                tick();
                if (pulse2) extra2++;
                if (pulse0) extra0++;
            end
            n_checks++; if (extra2 != 0) begin n_errors++; $display("FAIL cooldown2_midframe_pulses got=%0d exp=0", extra2); end
            n_checks++; if (extra0 != 0) begin n_errors++; $display("FAIL cooldown0_midframe_pulses got=%0d exp=0", extra0); end
        end
        n_checks++; if (cnt2 !== 8'd3) begin n_errors++; $display("FAIL cooldown2_count got=%0d exp=3", cnt2); end
        n_checks++; if (cnt0 !== 8'd9) begin n_errors++; $display("FAIL cooldown0_count got=%0d exp=9", cnt0); end
        playerDR     = 1'b0;
        tileDRVector = 4'b0000;
    endtask

    task automatic test_level_during_latched();
        level_clear();
        playerDR     = 1'b1;
        tileDRVector = 4'b0001;
        tick();
        playerDR     = 1'b0;
        tileDRVector = 4'b0000;
        tick();
        startOfLevel = 1'b1;
        startOfFrame = 1'b1;
        tick();
        startOfLevel = 1'b0;
        startOfFrame = 1'b0;
        n_checks++; if (pulse2 !== 1'b0) begin n_errors++; $display("FAIL level_pulse2 got=%0b exp=0", pulse2); end
        n_checks++; if (pulse0 !== 1'b0) begin n_errors++; $display("FAIL level_pulse0 got=%0b exp=0", pulse0); end
        n_checks++; if (cnt2 !== 8'd0)   begin n_errors++; $display("FAIL level_cnt2 got=%0d exp=0", cnt2); end
        tick();
        sof_tick();
        n_checks++; if (pulse2 !== 1'b0) begin n_errors++; $display("FAIL level_stale_report got=%0b exp=0", pulse2); end
    endtask

    task automatic test_saturation();
        int pulses;
        pulses = 0;
        level_clear();
        for (int f = 0; f <= 300; f++) begin
            sof_tick();
            if (pulse0) pulses++;
            if (f == 254) begin
                n_checks++; if (cnt0 !== 8'd254) begin n_errors++; $display("FAIL sat_mid_count got=%0d exp=254", cnt0); end
            end
            playerDR     = 1'b1;
            tileDRVector = 4'b0100;
            tick();
            playerDR     = 1'b0;
            tileDRVector = 4'b0000;
            tick();
            tick();
        end
        n_checks++; if (pulses != 300) begin n_errors++; $display("FAIL sat_pulses got=%0d exp=300", pulses); end
        n_checks++; if (cnt0 !== 8'd255) begin n_errors++; $display("FAIL sat_count got=%0d exp=255", cnt0); end
    endtask

    task automatic test_reset_mid_cooldown();
        level_clear();
        playerDR     = 1'b1;
        tileDRVector = 4'b0100;
        tick();
        playerDR     = 1'b0;
        tick();
        sof_tick();
        n_checks++; if (pulse2 !== 1'b1) begin n_errors++; $display("FAIL rst_setup_pulse got=%0b exp=1", pulse2); end
        tick();
        #2 resetN = 1'b0;
        #1;
        n_checks++; if (dr2 !== 1'b0)    begin n_errors++; $display("FAIL rst_async_dr got=%0b exp=0", dr2); end
        n_checks++; if (rgb2 !== 8'h00)  begin n_errors++; $display("FAIL rst_async_rgb got=%02h exp=00", rgb2); end
        n_checks++; if (idx2 !== 2'd0)   begin n_errors++; $display("FAIL rst_async_idx got=%0d exp=0", idx2); end
        n_checks++; if (cnt2 !== 8'd0)   begin n_errors++; $display("FAIL rst_async_cnt got=%0d exp=0", cnt2); end
        n_checks++; if (pulse2 !== 1'b0) begin n_errors++; $display("FAIL rst_async_pulse got=%0b exp=0", pulse2); end
        @(posedge clk);
        #1 resetN    = 1'b1;
        playerDR     = 1'b1;
        tileDRVector = 4'b1000;
        tick();
        playerDR     = 1'b0;
        tileDRVector = 4'b0000;
        tick();
        sof_tick();
        n_checks++; if (pulse2 !== 1'b1) begin n_errors++; $display("FAIL rst_first_hit_pulse got=%0b exp=1", pulse2); end
        n_checks++; if (idx2 !== 2'd3)   begin n_errors++; $display("FAIL rst_first_hit_idx got=%0d exp=3", idx2); end
        n_checks++; if (cnt2 !== 8'd1)   begin n_errors++; $display("FAIL rst_first_hit_cnt got=%0d exp=1", cnt2); end
    endtask

    initial begin
        resetN        = 1'b0;
        startOfFrame  = 1'b0;
        startOfLevel  = 1'b0;
        playerDR      = 1'b0;
        tileDRVector  = 4'b0000;
        tileRGBVector = '0;
        test_reset();
        test_merge();
        test_basic_hit();
        test_sof_coincident();
        test_cooldown();
        test_level_during_latched();
        test_saturation();
        test_reset_mid_cooldown();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
